// File: rtl/mdr_bus_ctrl_pkg.sv
// Shared definitions for the instruction-fetch / MDR bus controller:
// default widths, the ack timeout and the controller state encoding.
package fetch_bus_pkg;

    localparam int ADDR_W_DEF      = 32;
    localparam int DATA_W_DEF      = 36;
    localparam int ACK_TIMEOUT_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MEM_WAIT = 3'd1,
        ST_DRIVE    = 3'd2,
        ST_TURN     = 3'd3,
        ST_READ     = 3'd4,
        ST_RESP     = 3'd5
    } fetch_state_e;

    // Bits needed for a counter running 0 .. limit-1.
    function automatic int tmr_width(input int limit);
        return (limit <= 2) ? 1 : $clog2(limit);
    endfunction

endpackage

// File: rtl/mdr_bus_ctrl_if.sv
// Fetch-side, memory-side and IR-side handshakes of the MDR bus controller.
// The tri-state inst bus is kept out of here as a plain inout port.
interface mdr_bus_ctrl_if
    import fetch_bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ready;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              MDR_wr;
    logic              MDR_rd;
    logic [DATA_W-1:0] inst_out;
    logic              inst_valid;
    logic              inst_ready;
    logic              fetch_err;

    modport master (
        input  fetch_req, fetch_addr, mem_ack, mem_rdata, inst_ready,
        output fetch_ready, mem_req, mem_addr, MDR_wr, MDR_rd,
               inst_out, inst_valid, fetch_err
    );

    modport slave (
        output fetch_req, fetch_addr, mem_ack, mem_rdata, inst_ready,
        input  fetch_ready, mem_req, mem_addr, MDR_wr, MDR_rd,
               inst_out, inst_valid, fetch_err
    );
endinterface

// File: rtl/mdr_bus_ctrl_ack_timeout_ctr.sv
// Wait-cycle counter for the memory ack; saturates at LIMIT-1 and flags it.
module ack_timeout_ctr
    import fetch_bus_pkg::*;
#(
    parameter int LIMIT = ACK_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    localparam int            CW   = tmr_width(LIMIT);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] r_cnt;

    // Count wait cycles; clear on a new fetch, hold once the limit is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = (r_cnt == LAST);
endmodule

// File: rtl/mdr_bus_ctrl.sv
// Instruction fetch controller: reads a word from memory, writes it into the
// MDR over the shared tri-state inst bus, reads it back and hands the
// readback to the IR, flagging memory timeouts and readback mismatches.
module mdr_bus_ctrl
    import fetch_bus_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    mdr_bus_ctrl_if.master    bus,
    inout  wire  [DATA_W-1:0] inst
);
    fetch_state_e      r_state;
    fetch_state_e      w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_inst_out;
    logic              r_err;
    logic              w_accept;
    logic              w_capture;
    logic              w_timeout;
    logic              w_expired;
    logic              w_drive;

    assign w_accept  = (r_state == ST_IDLE) && bus.fetch_req;
    assign w_capture = (r_state == ST_MEM_WAIT) && bus.mem_ack;
    assign w_timeout = (r_state == ST_MEM_WAIT) && !bus.mem_ack && w_expired;

    ack_timeout_ctr #(.LIMIT(ACK_TIMEOUT)) u_tmr (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_accept),
        .i_en      ((r_state == ST_MEM_WAIT) && !bus.mem_ack),
        .o_expired (w_expired)
    );

    // State register; reset drops straight to IDLE, which also releases inst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and strobe decode; every strobe is a pure function of state.
    always_comb begin
        w_next          = r_state;
        w_drive         = 1'b0;
        bus.fetch_ready = 1'b0;
        bus.mem_req     = 1'b0;
        bus.MDR_wr      = 1'b0;
        bus.MDR_rd      = 1'b0;
        bus.inst_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                bus.fetch_ready = 1'b1;
                if (bus.fetch_req) w_next = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ack)     w_next = ST_DRIVE;
                else if (w_expired)  w_next = ST_RESP;
            end
            ST_DRIVE: begin
                w_drive    = 1'b1;
                bus.MDR_wr = 1'b1;
                w_next     = ST_TURN;
            end
            ST_TURN: begin
                w_next = ST_READ;
            end
            ST_READ: begin
                bus.MDR_rd = 1'b1;
                w_next     = ST_RESP;
            end
            ST_RESP: begin
                bus.inst_valid = 1'b1;
                if (bus.inst_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Address, response word and error flag; all visible outputs reset to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_inst_out <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_accept) r_addr <= bus.fetch_addr;
            if (w_timeout) begin
                r_inst_out <= '0;
                r_err      <= 1'b1;
            end else if (r_state == ST_READ) begin
                r_inst_out <= inst;
                r_err      <= (inst != r_data);
            end
        end
    end

    // Memory data held for the MDR write and the readback compare.
    always_ff @(posedge clk) begin
        if (w_capture) r_data <= bus.mem_rdata;
    end

    assign inst         = w_drive ? r_data : {DATA_W{1'bz}};
    assign bus.mem_addr = r_addr;
    assign bus.inst_out = r_inst_out;
    assign bus.fetch_err = r_err;
endmodule
